// File: rtl/program_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
// master drives bytes, slave (the loader) returns ready.
interface program_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader.sv
// Purpose: boot loader; frames (len, payload, xor csum) -> 32-bit imem writes, holds cpu in reset until verified.
// Latency: imem_we pulses the cycle after a word's 4th byte is accepted; done/cpu_reset change on the csum-accept edge.
// Backpressure: rx_ready = busy; no bubbles while loading, ready drops only in DONE/ERROR until load_req.
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    program_loader_if.slave       rx,
    input  logic                  load_req,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  csum;
    logic [1:0]  lane;
    logic [23:0] asm_word;
    logic        xfer;

    assign busy        = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                         (state == S_DATA)   || (state == S_CSUM);
    assign done        = (state == S_DONE);
    assign error       = (state == S_ERROR);
    assign rx.rx_ready = busy;
    assign xfer        = rx.rx_valid && busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_LEN_LO;
            cpu_reset    <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            csum         <= '0;
            lane         <= '0;
            len_lo       <= '0;
            len          <= '0;
            asm_word     <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= rx.rx_data;
                        csum   <= csum ^ rx.rx_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len  <= {rx.rx_data, len_lo};
                        csum <= csum ^ rx.rx_data;
                        if ({1'b0, rx.rx_data, len_lo} > MAX_N)
                            state <= S_ERROR;
                        else if ({rx.rx_data, len_lo} == 16'd0)
                            state <= S_CSUM;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum <= csum ^ rx.rx_data;
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: asm_word[7:0]   <= rx.rx_data;
                            2'd1: asm_word[15:8]  <= rx.rx_data;
                            2'd2: asm_word[23:16] <= rx.rx_data;
                            default: begin
                                // Lane 3 completes the word: write it straight out, no assembly bubble.
                                imem_wdata   <= {rx.rx_data, asm_word};
                                imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                                imem_we      <= 1'b1;
                                words_loaded <= words_loaded + 16'd1;
                                if (words_loaded + 16'd1 == len)
                                    state <= S_CSUM;
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        if (rx.rx_data == csum) begin
                            state     <= S_DONE;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (load_req) begin
                        state        <= S_LEN_LO;
                        cpu_reset    <= 1'b1;
                        words_loaded <= '0;
                        csum         <= '0;
                        lane         <= '0;
                    end
                end
                default: state <= S_LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected imem writes go into a scoreboard queue,
// a negedge monitor pops and compares each write; status is checked after each frame.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_req = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset, busy, done, error;
    logic [15:0] words_loaded;

    int tests  = 0;
    int failed = 0;

    logic [39:0] sb[$];
    logic [7:0]  frame[$];

    program_loader_if rx();

    program_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx.slave),
        .load_req     (load_req),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every imem_we must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                logic [39:0] e;
                e = sb.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    failed++;
                    $display("FAIL imem_write: got addr %h data %h expected addr %h data %h",
                             imem_addr, imem_wdata, e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx.rx_data  = b;
        rx.rx_valid = 1'b1;
        while (!rx.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx.rx_ready) begin
            tests++;
            failed++;
            $display("FAIL rx_ready_timeout: got ready 0 expected 1 for byte %h", b);
        end
        @(posedge clk);
        #1 rx.rx_valid = 1'b0;
    endtask

    task automatic pulse_load_req();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    // Sends frame[]; optional random gaps and a load_req pulse before byte index lr_at.
    task automatic send_frame(input int max_gap, input int lr_at);
        for (int i = 0; i < frame.size(); i++) begin
            if (i == lr_at) begin
                pulse_load_req();
                chk("busy_after_midload_req", {31'd0, busy}, 32'd1);
            end
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(frame[i]);
        end
    endtask

    task automatic set_nominal(input logic [7:0] cs);
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        frame.push_back(cs);
        sb.push_back({8'h00, 32'h0050_0093});
        sb.push_back({8'h01, 32'h0010_0113});
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e,
                              input logic cr, input logic [15:0] wl);
        @(negedge clk);
        chk({tag, "_done"},      {31'd0, done},      {31'd0, d});
        chk({tag, "_error"},     {31'd0, error},     {31'd0, e});
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
        chk({tag, "_words"},     {16'd0, words_loaded}, {16'd0, wl});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rx.rx_data  = 8'h00;
        rx.rx_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_imem_we",   {31'd0, imem_we},   32'd0);
        chk("rst_addr",      {24'd0, imem_addr}, 32'd0);
        chk("rst_wdata",     imem_wdata,         32'd0);
        chk("rst_words",     {16'd0, words_loaded}, 32'd0);
        chk("rst_rx_ready",  {31'd0, rx.rx_ready}, 32'd1);
        rst = 1'b1;

        // Nominal back-to-back
        set_nominal(8'hC3);
        send_frame(0, -1);
        chk_status("nominal", 1'b1, 1'b0, 1'b0, 16'd2);
        chk("done_rx_ready", {31'd0, rx.rx_ready}, 32'd0);

        // Reload from DONE re-asserts cpu_reset, clears count
        pulse_load_req();
        chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("reload_busy",      {31'd0, busy},      32'd1);
        chk("reload_words",     {16'd0, words_loaded}, 32'd0);

        // Zero length
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0, -1);
        chk_status("zero_len", 1'b1, 1'b0, 1'b0, 16'd0);

        // Oversize N = 257
        pulse_load_req();
        frame = '{8'h01, 8'h01};
        send_frame(0, -1);
        @(negedge clk);
        chk("oversize_error",     {31'd0, error},       32'd1);
        chk("oversize_rx_ready",  {31'd0, rx.rx_ready}, 32'd0);
        chk("oversize_cpu_reset", {31'd0, cpu_reset},   32'd1);
        chk("oversize_words",     {16'd0, words_loaded}, 32'd0);

        // Bad checksum: words still written, then ERROR
        pulse_load_req();
        set_nominal(8'hC2);
        send_frame(0, -1);
        chk_status("bad_csum", 1'b0, 1'b1, 1'b1, 16'd2);

        // Recovery after error
        pulse_load_req();
        set_nominal(8'hC3);
        send_frame(0, -1);
        chk_status("recover", 1'b1, 1'b0, 1'b0, 16'd2);

        // Random gaps with ignored load_req mid-DATA
        pulse_load_req();
        set_nominal(8'hC3);
        send_frame(5, 5);
        chk_status("gaps", 1'b1, 1'b0, 1'b0, 16'd2);

        // Async reset after 6 payload bytes (word 0 written first)
        pulse_load_req();
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
        sb.push_back({8'h00, 32'h0050_0093});
        send_frame(0, -1);
        @(negedge clk);
        chk("mid_words_before", {16'd0, words_loaded}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("arst_imem_we",   {31'd0, imem_we},   32'd0);
        chk("arst_addr",      {24'd0, imem_addr}, 32'd0);
        chk("arst_wdata",     imem_wdata,         32'd0);
        chk("arst_words",     {16'd0, words_loaded}, 32'd0);
        chk("arst_busy",      {31'd0, busy},      32'd1);
        @(negedge clk) rst = 1'b1;

        set_nominal(8'hC3);
        send_frame(0, -1);
        chk_status("post_arst", 1'b1, 1'b0, 1'b0, 16'd2);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time program loader placed upstream of the single-cycle RISC-V processor. It receives a framed byte stream (length, payload, checksum) over a valid/ready byte interface and assembles little-endian 32-bit instruction words. It writes those words into instruction memory at consecutive word addresses starting at 0. It holds the processor in reset until a complete, checksum-verified image has been written.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width
MAX_WORDS, 256, largest accepted image in words; must be <= 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte; combinational from state
load_req  input  1  single-cycle request to reload; honoured only in DONE or ERROR
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address for the write
imem_wdata  output  32  word to write
cpu_reset  output  1  1 = hold processor in reset
busy  output  1  high in LEN_LO, LEN_HI, DATA, CSUM
done  output  1  high in DONE
error  output  1  high in ERROR
words_loaded  output  16  count of words written in the current load

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes (LSB first per word), then one checksum byte.
- Checksum: XOR of every byte from LEN_LO through the last payload byte.
- Handshake: a byte transfers on a rising edge where rx_valid && rx_ready. rx_valid gaps of any length are legal. rx_ready = busy.
- Reset (rst low, async) forces:
  - state LEN_LO, cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0;
  - words_loaded=0, checksum=0, byte-lane counter=0.
  - After rst deasserts, the loader accepts bytes immediately.
- Reset mid-load discards the partial frame. Words already written remain in memory.
- States:
  - LEN_LO: accept byte -> store length[7:0] -> LEN_HI.
  - LEN_HI: accept byte -> form N.
    - N > MAX_WORDS -> ERROR.
    - N == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: bytes fill lanes 0..3 of the assembly register. On the 4th byte's handshake cycle, register imem_wdata = assembled word and imem_addr = words_loaded[ADDR_WIDTH-1:0]. imem_we is high for exactly the following cycle, and words_loaded increments on that same edge. After word N is accepted -> CSUM. rx_ready stays high while imem_we pulses, so no bubble is required.
  - CSUM: accept byte. Equal to running XOR -> DONE; otherwise -> ERROR.
  - DONE: cpu_reset=0, done=1. load_req -> LEN_LO with cpu_reset=1, counters and checksum cleared.
  - ERROR: cpu_reset=1, error=1. load_req -> LEN_LO with counters cleared.
- load_req in any busy state is ignored.
- imem_addr never wraps, because N <= MAX_WORDS <= 2**ADDR_WIDTH.
- cpu_reset falls on the same edge that enters DONE and rises on the edge that leaves DONE.
- imem_wdata and imem_addr hold their last values when imem_we=0.

Test Plan:
- Nominal 2-word load:
  - Send 02 00 | 93 00 50 00 | 13 01 10 00 | C3.
  - Expect two imem_we pulses: addr0=0x00500093, addr1=0x00100113.
  - Expect done=1, cpu_reset=0, words_loaded=2.
- Zero length: send 00 00 00 -> no imem_we, DONE, cpu_reset=0, words_loaded=0.
- Oversize: send 01 01 (N=257) -> ERROR on the cycle after LEN_HI accept, rx_ready=0, cpu_reset=1, no writes.
- Bad checksum: repeat the nominal frame with checksum C2 -> both words still written, then ERROR, cpu_reset stays 1.
  - Then pulse load_req and resend the nominal frame -> DONE.
- Backpressure/gaps:
  - Nominal frame with rx_valid low for 0-5 random cycles between bytes gives identical writes and result.
  - load_req pulsed mid-DATA has no effect.
- Async reset mid-DATA:
  - Assert rst low after 6 payload bytes -> outputs return to reset values immediately without a clock.
  - Then a fresh nominal frame loads correctly.
